// File: rtl/jelly_img_gamma_interp_core.sv
// Per-channel gamma mapping through a double-buffered lookup table, optionally interpolated.
// Latency: 4 cke-qualified cycles from s_* to m_*, in mapping and bypass mode alike.
// Backpressure: none downstream; cke=0 freezes pipeline and swap logic, table writes continue.
//
// Ports:
//   clk, reset_n (async, active-low), cke (pipeline enable), enable (1=map, 0=bypass)
//   mem_en/mem_ch/mem_addr/mem_din : write port into the inactive table bank
//   update_req / update_ack        : bank swap request, acknowledged on the next frame start
//   s_valid/s_frame_start/s_data   : input pixels, CHANNELS x S_DATA_WIDTH
//   m_valid/m_frame_start/m_data   : output pixels, CHANNELS x M_DATA_WIDTH
// Build option: define JELLY_IMG_GAMMA_INTERP_EN to linearly interpolate between
// adjacent entries; otherwise the output is table[i] and the fraction is ignored.

module jelly_img_gamma_interp_core #(
  parameter int    CHANNELS       = 3,
  parameter int    S_DATA_WIDTH   = 10,
  parameter int    M_DATA_WIDTH   = 8,
  parameter int    TBL_ADDR_WIDTH = 6,
  parameter string RAM_TYPE       = "distributed",
  localparam int   CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cke,
  input  logic                               enable,

  input  logic                               mem_en,
  input  logic [CH_W-1:0]                    mem_ch,
  input  logic [TBL_ADDR_WIDTH:0]            mem_addr,
  input  logic [M_DATA_WIDTH-1:0]            mem_din,

  input  logic                               update_req,
  output logic                               update_ack,

  input  logic                               s_valid,
  input  logic                               s_frame_start,
  input  logic [CHANNELS*S_DATA_WIDTH-1:0]   s_data,

  output logic                               m_valid,
  output logic                               m_frame_start,
  output logic [CHANNELS*M_DATA_WIDTH-1:0]   m_data
);

  localparam int S        = S_DATA_WIDTH;
  localparam int M        = M_DATA_WIDTH;
  localparam int T        = TBL_ADDR_WIDTH;
  localparam int FRAC     = S - T;
  localparam int TBL_SIZE = (1 << T) + 1;
`ifdef JELLY_IMG_GAMMA_INTERP_EN
  localparam int RD_W     = 2 * M;   // a and b entries read together
`else
  localparam int RD_W     = M;
`endif

  // ---------------------------------------------------------------
  // Table storage: [bank][channel][entry]; contents are never reset
  // ---------------------------------------------------------------
  logic [M-1:0] tbl_mem [0:1][0:CHANNELS-1][0:TBL_SIZE-1];
  logic         active_bank;

  always_ff @(posedge clk) begin
    if (mem_en && (int'(mem_ch) < CHANNELS) && (int'(mem_addr) < TBL_SIZE)) begin
      tbl_mem[~active_bank][mem_ch][mem_addr] <= mem_din;
    end
  end

  // ---------------------------------------------------------------
  // Bank swap: pending request is honoured on the next frame start
  // ---------------------------------------------------------------
  logic pending;
  logic swap;

  assign swap = cke & s_valid & s_frame_start & pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= 1'b0;
      active_bank <= 1'b0;
      update_ack  <= 1'b0;
    end else begin
      update_ack <= swap;
      if (swap) begin
        active_bank <= ~active_bank;
        // a request landing on the swap cycle is kept for the next frame
        pending     <= update_req;
      end else if (update_req) begin
        pending     <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Shared control pipeline
  // ---------------------------------------------------------------
  logic                  st0_vld, st0_fs, st0_en, st0_bank;
  logic [CHANNELS*S-1:0] st0_dat;
  logic                  st1_vld, st1_fs, st1_en;
  logic                  st2_vld, st2_fs, st2_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st0_vld       <= 1'b0;
      st0_fs        <= 1'b0;
      st0_en        <= 1'b0;
      st0_bank      <= 1'b0;
      st0_dat       <= '0;
      st1_vld       <= 1'b0;
      st1_fs        <= 1'b0;
      st1_en        <= 1'b0;
      st2_vld       <= 1'b0;
      st2_fs        <= 1'b0;
      st2_en        <= 1'b0;
      m_valid       <= 1'b0;
      m_frame_start <= 1'b0;
    end else if (cke) begin
      st0_vld       <= s_valid;
      st0_fs        <= s_frame_start;
      st0_en        <= enable;
      // the frame-start pixel that triggers the swap already uses the new bank
      st0_bank      <= active_bank ^ swap;
      st0_dat       <= s_data;
      st1_vld       <= st0_vld;
      st1_fs        <= st0_fs;
      st1_en        <= st0_en;
      st2_vld       <= st1_vld;
      st2_fs        <= st1_fs;
      st2_en        <= st1_en;
      m_valid       <= st2_vld;
      m_frame_start <= st2_fs;
    end
  end

  // ---------------------------------------------------------------
  // Per-channel datapath
  // ---------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [S-1:0]    px;
    logic [T-1:0]    idx;
    logic [T:0]      addr_a;
    logic [M-1:0]    byp;
    logic [RD_W-1:0] rd_ab;
    logic [RD_W-1:0] st1_ab;
    logic [M-1:0]    st1_byp;
    logic [M-1:0]    st2_a;
    logic [M-1:0]    st2_byp;
    logic [M-1:0]    out_dat;

    assign px     = st0_dat[c*S +: S];
    assign idx    = px[S-1 -: T];
    assign addr_a = {1'b0, idx};

    if (S >= M) begin : g_byp_shr
      assign byp = px[S-1 -: M];
    end else begin : g_byp_shl
      // left-justify and replicate the top bits into the vacated LSBs
      assign byp = {px, {(M-S){1'b0}}} | M'(px >> (2*S-M));
    end

`ifdef JELLY_IMG_GAMMA_INTERP_EN
    logic [T:0] addr_b;
    assign addr_b = addr_a + (T+1)'(1);
    assign rd_ab  = {tbl_mem[st0_bank][c][addr_b], tbl_mem[st0_bank][c][addr_a]};
`else
    logic unused_frac;
    assign unused_frac = ^px[FRAC-1:0];
    assign rd_ab       = tbl_mem[st0_bank][c][addr_a];
`endif

    // block RAM output registers cannot take an async reset; the valid
    // pipeline already masks whatever they hold after reset
    if (RAM_TYPE == "block") begin : g_rd_block
      always_ff @(posedge clk) begin
        if (cke) st1_ab <= rd_ab;
      end
    end else begin : g_rd_dist
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  st1_ab <= '0;
        else if (cke)  st1_ab <= rd_ab;
      end
    end

`ifdef JELLY_IMG_GAMMA_INTERP_EN
    logic [FRAC-1:0]          st1_f;
    logic signed [M:0]        diff;
    logic signed [M+FRAC+1:0] prod;
    logic signed [M+FRAC+1:0] st2_prod;

    // signed difference times unsigned fraction; the later arithmetic
    // shift gives floor division, so the result stays between a and b
    assign diff = $signed({1'b0, st1_ab[2*M-1:M]}) - $signed({1'b0, st1_ab[M-1:0]});
    assign prod = (M+FRAC+2)'(diff) * (M+FRAC+2)'($signed({1'b0, st1_f}));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st1_f    <= '0;
        st1_byp  <= '0;
        st2_a    <= '0;
        st2_prod <= '0;
        st2_byp  <= '0;
        out_dat  <= '0;
      end else if (cke) begin
        st1_f    <= px[FRAC-1:0];
        st1_byp  <= byp;
        st2_a    <= st1_ab[M-1:0];
        st2_prod <= prod;
        st2_byp  <= st1_byp;
        out_dat  <= st2_en ? M'($signed({{(FRAC+2){1'b0}}, st2_a}) + (st2_prod >>> FRAC))
                           : st2_byp;
      end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st1_byp <= '0;
        st2_a   <= '0;
        st2_byp <= '0;
        out_dat <= '0;
      end else if (cke) begin
        st1_byp <= byp;
        st2_a   <= st1_ab;
        st2_byp <= st1_byp;
        out_dat <= st2_en ? st2_a : st2_byp;
      end
    end
`endif

    assign m_data[c*M +: M] = out_dat;
  end

endmodule

// File: tb/tb_jelly_img_gamma_interp_core.sv
// Bench for jelly_img_gamma_interp_core: directed scenarios plus random traffic.
// Expected pixels are computed from the table arithmetic at input time and
// delayed by four enabled cycles before being compared with the outputs.

module tb_jelly_img_gamma_interp_core;

  localparam int CH = 1;
  localparam int S  = 10;
  localparam int M  = 8;
  localparam int T  = 6;
  localparam int FR = S - T;
  localparam int NE = (1 << T) + 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cke = 1'b1;
  logic         enable = 1'b1;
  logic         mem_en = 1'b0;
  logic [0:0]   mem_ch = '0;
  logic [T:0]   mem_addr = '0;
  logic [M-1:0] mem_din = '0;
  logic         update_req = 1'b0;
  logic         update_ack;
  logic         s_valid = 1'b0;
  logic         s_frame_start = 1'b0;
  logic [S-1:0] s_data = '0;
  logic         m_valid;
  logic         m_frame_start;
  logic [M-1:0] m_data;

  jelly_img_gamma_interp_core #(
    .CHANNELS      (CH),
    .S_DATA_WIDTH  (S),
    .M_DATA_WIDTH  (M),
    .TBL_ADDR_WIDTH(T)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cke           (cke),
    .enable        (enable),
    .mem_en        (mem_en),
    .mem_ch        (mem_ch),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .update_req    (update_req),
    .update_ack    (update_ack),
    .s_valid       (s_valid),
    .s_frame_start (s_frame_start),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_frame_start (m_frame_start),
    .m_data        (m_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state
  int tbl [2][NE];
  int act  = 0;
  bit pend = 1'b0;
  bit pv [4];
  bit pf [4];
  int pd [4];
  bit exp_ack = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_pix(input int bank, input int sd, input bit en);
    int i, f, a, d, q;
    if (!en) return sd >> (S - M);
    i = sd >> FR;
    f = sd % (1 << FR);
    a = tbl[bank][i];
`ifdef JELLY_IMG_GAMMA_INTERP_EN
    d = (tbl[bank][i+1] - a) * f;
    q = (d >= 0) ? d / (1 << FR) : -((-d + (1 << FR) - 1) / (1 << FR));
    return a + q;
`else
    d = f;
    q = d * 0;
    return a + q;
`endif
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      pv[k] = 1'b0; pf[k] = 1'b0; pd[k] = 0;
    end
    act = 0; pend = 1'b0; exp_ack = 1'b0;
  endtask

  // one clock: advance the model with the inputs presented, then compare
  task automatic step();
    bit sw;
    @(posedge clk);
    if (mem_en && mem_ch == 1'b0 && int'(mem_addr) < NE)
      tbl[1-act][mem_addr] = int'(mem_din);
    if (cke) begin
      sw = pend && s_valid && s_frame_start;
      for (int k = 3; k > 0; k--) begin
        pv[k] = pv[k-1]; pf[k] = pf[k-1]; pd[k] = pd[k-1];
      end
      pv[0] = s_valid;
      pf[0] = s_frame_start;
      pd[0] = ref_pix(sw ? 1 - act : act, int'(s_data), enable);
      exp_ack = sw;
      if (sw) begin
        act  = 1 - act;
        pend = update_req;
      end else if (update_req) begin
        pend = 1'b1;
      end
    end else begin
      exp_ack = 1'b0;
      if (update_req) pend = 1'b1;
    end
    #1;
    check("m_valid", int'(m_valid), int'(pv[3]));
    check("m_frame_start", int'(m_frame_start), int'(pf[3]));
    check("update_ack", int'(update_ack), int'(exp_ack));
    if (pv[3]) check("m_data", int'(m_data), pd[3]);
  endtask

  task automatic wr(input int addr, input int din);
    mem_en = 1'b1; mem_ch = 1'b0;
    mem_addr = (T+1)'(addr); mem_din = M'(din);
    step();
    mem_en = 1'b0;
  endtask

  task automatic fill_inactive(input bit rnd, input int cval);
    for (int a = 0; a < NE; a++) wr(a, rnd ? int'($urandom_range(0, 255)) : cval);
  endtask

  task automatic pix(input int d, input bit fs);
    s_valid = 1'b1; s_frame_start = fs; s_data = S'(d);
    step();
    s_valid = 1'b0; s_frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_swap();
    update_req = 1'b1;
    step();
    update_req = 1'b0;
    pix(int'($urandom_range(0, 1023)), 1'b1);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_frame_start", int'(m_frame_start), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_update_ack", int'(update_ack), 0);
    reset_n = 1'b1;

    // rising segment: 16 -> 48, 88 lies at i=5, f=8
    fill_inactive(1'b1, 0);
    wr(5, 16); wr(6, 48);
    do_swap();
    pix(88, 1'b0);
    idle(5);

    // falling segment: 48 -> 16, checks floor toward minus infinity
    fill_inactive(1'b1, 0);
    wr(5, 48); wr(6, 16);
    do_swap();
    pix(88, 1'b0);
    pix(81, 1'b0);
    idle(5);

    // writes to a nonexistent channel must be dropped
    mem_en = 1'b1; mem_ch = 1'b1; mem_addr = 7'd5; mem_din = 8'd99;
    step();
    mem_en = 1'b0; mem_ch = 1'b0;

    // bypass
    enable = 1'b0;
    pix(10'h3FF, 1'b0);
    pix(10'h200, 1'b0);
    idle(5);
    enable = 1'b1;

    // swap only on a frame start, never mid-frame
    fill_inactive(1'b0, 10);
    do_swap();
    fill_inactive(1'b0, 200);
    pix(300, 1'b1);
    pix(301, 1'b0);
    update_req = 1'b1;
    pix(302, 1'b0);
    update_req = 1'b0;
    for (int k = 0; k < 4; k++) pix(int'($urandom_range(0, 1023)), 1'b0);
    idle(2);
    pix(400, 1'b1);
    pix(401, 1'b0);
    idle(5);

    // clock-enable stall mid-stream
    for (int k = 0; k < 10; k++) begin
      cke = (k >= 4 && k < 7) ? 1'b0 : 1'b1;
      pix(int'($urandom_range(0, 1023)), 1'b0);
    end
    cke = 1'b1;
    idle(5);

    // asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) pix(int'($urandom_range(0, 1023)), 1'b0);
    reset_n = 1'b0;
    #1;
    check("arst_m_valid", int'(m_valid), 0);
    check("arst_update_ack", int'(update_ack), 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);
    pix(520, 1'b0);
    idle(6);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      mem_en        = ($urandom_range(0, 3) == 0);
      mem_ch        = 1'($urandom_range(0, 1));
      mem_addr      = (T+1)'($urandom_range(0, 127));
      mem_din       = M'($urandom_range(0, 255));
      cke           = ($urandom_range(0, 99) < 85);
      enable        = ($urandom_range(0, 99) < 80);
      s_valid       = ($urandom_range(0, 99) < 60);
      s_frame_start = ($urandom_range(0, 99) < 10);
      update_req    = ($urandom_range(0, 99) < 5);
      s_data        = S'($urandom_range(0, 1023));
      step();
    end
    mem_en = 1'b0; cke = 1'b1; s_valid = 1'b0; s_frame_start = 1'b0; update_req = 1'b0;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
